// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: requester-side and FPU-side signals of the shared-FPU arbiter.
// The slave modport is the arbiter's view. The master modport is the view
// of whatever surrounds it: the requesters plus the FPU core.
interface fpu_arbiter_if #(
  parameter int NREQ = 4
);
  // Requester side: one slice of each bus per requester.
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_A;
  logic [32*NREQ-1:0] req_B;
  logic [2*NREQ-1:0] req_Sel;
  logic [2*NREQ-1:0] req_round;

  // FPU core side.
  logic [31:0]       fpu_A;
  logic [31:0]       fpu_B;
  logic [1:0]        fpu_Sel;
  logic [1:0]        fpu_round;
  logic              fpu_start;
  logic [31:0]       fpu_Y;
  logic              fpu_Error;
  logic              fpu_Overflow;

  // Response side: the result bus is shared and the strobe is one-hot.
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_Y;
  logic              rsp_Error;
  logic              rsp_Overflow;

  modport slave (
    input  req_valid, req_A, req_B, req_Sel, req_round,
    input  fpu_Y, fpu_Error, fpu_Overflow,
    output req_ready,
    output fpu_A, fpu_B, fpu_Sel, fpu_round, fpu_start,
    output rsp_valid, rsp_Y, rsp_Error, rsp_Overflow
  );

  modport master (
    output req_valid, req_A, req_B, req_Sel, req_round,
    output fpu_Y, fpu_Error, fpu_Overflow,
    input  req_ready,
    input  fpu_A, fpu_B, fpu_Sel, fpu_round, fpu_start,
    input  rsp_valid, rsp_Y, rsp_Error, rsp_Overflow
  );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fixed-latency FPU core among NREQ requesters.
// Grants go round-robin, and only one operation is in flight at a time.
// The FPU has no done signal, so a counter sets the moment at which the
// result is captured.
// Optional build macro FPU_ARB_STATS_EN adds the err_cnt and ovf_cnt
// saturating event counters. The block is complete without it.
module fpu_arbiter #(
  parameter int NREQ    = 4,  // requesters, 2..8
  parameter int LATENCY = 4   // FPU start cycle to result-valid cycle, >= 1
) (
  input  logic         clk,
  input  logic         rst,
  fpu_arbiter_if.slave bus,
  output logic         busy
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [15:0]  err_cnt,
  output logic [15:0]  ovf_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LATENCY + 1);

  // One extra bit so that last + k (k <= NREQ) cannot overflow before the wrap.
  typedef logic [IW:0] wide_idx_t;

  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;        // most recent grant; also owner of the op in flight
  logic [CW-1:0]   cnt;         // cycles since the FPU start; saturates at LATENCY

  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  wide_idx_t       sum;
  logic [31:0]     sel_A;
  logic [31:0]     sel_B;
  logic [1:0]      sel_Sel;
  logic [1:0]      sel_round;

  // Round-robin search: the first valid requester after last, with wrap-around.
  // NOTE: every signal written in always_comb gets a default value first; without that, any path that skips an assignment would infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = wide_idx_t'(last) + wide_idx_t'(k);
      if (sum >= wide_idx_t'(NREQ)) sum = sum - wide_idx_t'(NREQ);
      if (!grant_found && bus.req_valid[sum[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[IW-1:0];
      end
    end
  end

  // Select the winning requester's operands for latching.
  always_comb begin
    sel_A     = '0;
    sel_B     = '0;
    sel_Sel   = '0;
    sel_round = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_A     = bus.req_A[32*i +: 32];
        sel_B     = bus.req_B[32*i +: 32];
        sel_Sel   = bus.req_Sel[2*i +: 2];
        sel_round = bus.req_round[2*i +: 2];
      end
    end
  end

  // Ready is combinational, so a requester learns in the same cycle that it was accepted.
  // It is held low during reset so that no acceptance is advertised that will not take effect.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !rst && grant_found) bus.req_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Control FSM: grant, issue the start pulse, count the FPU latency, return the result.
  // NOTE: sequential state uses non-blocking assignments, so every register in this block samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      last             <= LAST_RST;
      cnt              <= '0;
      bus.fpu_A        <= '0;
      bus.fpu_B        <= '0;
      bus.fpu_Sel      <= '0;
      bus.fpu_round    <= '0;
      bus.fpu_start    <= 1'b0;
      bus.rsp_valid    <= '0;
      bus.rsp_Y        <= '0;
      bus.rsp_Error    <= 1'b0;
      bus.rsp_Overflow <= 1'b0;
    end else begin
      bus.fpu_start <= 1'b0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            // The operands stay in these registers until the next grant.
            // That keeps the FPU inputs stable across the whole operation.
            bus.fpu_A     <= sel_A;
            bus.fpu_B     <= sel_B;
            bus.fpu_Sel   <= sel_Sel;
            bus.fpu_round <= sel_round;
            bus.fpu_start <= 1'b1;
            last          <= grant_idx;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CW'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_DONE) begin
            bus.rsp_Y        <= bus.fpu_Y;
            bus.rsp_Error    <= bus.fpu_Error;
            bus.rsp_Overflow <= bus.fpu_Overflow;
            bus.rsp_valid[last] <= 1'b1;
            state            <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPU_ARB_STATS_EN
  // Count the returned error and overflow results. Both counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else if (state == RESP) begin
      if (bus.rsp_Error && err_cnt != 16'hFFFF)    err_cnt <= err_cnt + 16'd1;
      if (bus.rsp_Overflow && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: self-checking bench for fpu_arbiter with NREQ=4 and LATENCY=4.
// A behavioural FPU drives a valid result only in the cycle LATENCY after the
// start pulse. In every other cycle it drives a recognisable junk value.
// Grants push expected responses to a scoreboard, and responses pop them.
module tb_fpu_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 4;

  typedef struct packed {
    logic [31:0] y;
    logic        e;
    logic        o;
  } res_t;

  typedef struct {
    int   idx;
    res_t r;
    int   due;
  } sb_t;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [1:0]  rnd;
    logic [31:0] y;
    logic        e;
    logic        o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef FPU_ARB_STATS_EN
  logic [15:0] err_cnt;
  logic [15:0] ovf_cnt;
`endif

  fpu_arbiter_if #(.NREQ(NREQ)) bus ();

  fpu_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef FPU_ARB_STATS_EN
    ,
    .err_cnt (err_cnt),
    .ovf_cnt (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural FPU ----------------
  function automatic real sp2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic res_t fpu_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] sel);
    res_t r;
    r = '0;
    case (sel)
      2'd0:    r.y = r2sp(sp2r(a) + sp2r(b));
      2'd1:    r.y = r2sp(sp2r(a) - sp2r(b));
      2'd2:    begin r.y = 32'h7F80_0000; r.o = 1'b1; end
      default: begin r.y = 32'h7FC0_0000; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  logic [3:0] m_cnt = '0;
  res_t       m_res = '0;

  always @(posedge clk) begin
    if (bus.fpu_start) begin
      m_cnt <= 4'd1;
      m_res <= fpu_model(bus.fpu_A, bus.fpu_B, bus.fpu_Sel);
    end else if (m_cnt != 4'd0 && m_cnt != 4'd15) begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  assign bus.fpu_Y        = (m_cnt == 4'(LAT)) ? m_res.y : 32'hDEAD_BEEF;
  assign bus.fpu_Error    = (m_cnt == 4'(LAT)) ? m_res.e : 1'b1;
  assign bus.fpu_Overflow = (m_cnt == 4'(LAT)) ? m_res.o : 1'b1;

  // ---------------- requester drive ----------------
  logic [31:0] p_a   [NREQ];
  logic [31:0] p_b   [NREQ];
  logic [1:0]  p_sel [NREQ];
  logic [1:0]  p_rnd [NREQ];

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sel, input logic [1:0] rnd);
    p_a[i] = a; p_b[i] = b; p_sel[i] = sel; p_rnd[i] = rnd;
    bus.req_A[32*i +: 32]   = a;
    bus.req_B[32*i +: 32]   = b;
    bus.req_Sel[2*i +: 2]   = sel;
    bus.req_round[2*i +: 2] = rnd;
  endtask

  // ---------------- monitor and scoreboard ----------------
  sb_t         sb_q[$];
  int          grant_q[$];
  int          grant_cyc_q[$];
  int          g_last_cyc = -100;
  logic [31:0] g_a, g_b;
  logic [1:0]  g_sel, g_rnd;
  int          mon_gi;
  sb_t         mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) check("ready_while_busy", bus.req_ready, 0);
      if (bus.req_ready != '0) begin
        check("ready_onehot", $onehot(bus.req_ready), 1);
        mon_gi = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) mon_gi = i;
        mon_e.idx = mon_gi;
        mon_e.r   = fpu_model(p_a[mon_gi], p_b[mon_gi], p_sel[mon_gi]);
        mon_e.due = cyc + LAT + 2;
        sb_q.push_back(mon_e);
        grant_q.push_back(mon_gi);
        grant_cyc_q.push_back(cyc);
        g_last_cyc = cyc;
        g_a = p_a[mon_gi]; g_b = p_b[mon_gi]; g_sel = p_sel[mon_gi]; g_rnd = p_rnd[mon_gi];
      end
      if (bus.fpu_start) begin
        check("start_cycle", cyc, g_last_cyc + 1);
        check("start_A", bus.fpu_A, g_a);
        check("start_B", bus.fpu_B, g_b);
        check("start_Sel", bus.fpu_Sel, g_sel);
        check("start_round", bus.fpu_round, g_rnd);
      end
      if (bus.rsp_valid != '0) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_rsp_valid", bus.rsp_valid, 1 << mon_e.idx);
          check("sb_rsp_cycle", cyc, mon_e.due);
          check("sb_rsp_Y", bus.rsp_Y, mon_e.r.y);
          check("sb_rsp_Error", bus.rsp_Error, mon_e.r.e);
          check("sb_rsp_Overflow", bus.rsp_Overflow, mon_e.r.o);
        end
      end
    end
  end

  // ---------------- helper tasks (called at posedge + 1) ----------------
  task automatic wait_ready(input int i, input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output int at,
                          output logic [NREQ-1:0] rv);
    ok = 1'b0;
    at = 0;
    rv = '0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin ok = 1'b1; at = cyc; rv = bus.rsp_valid; end
    end
  endtask

  task automatic single_op(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] sel, input logic [1:0] rnd, output int c0);
    bit ok;
    set_req(i, a, b, sel, rnd);
    bus.req_valid[i] = 1'b1;
    wait_ready(i, 20, ok, c0);
    check("op_ready", ok, 1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) done = 1'b1;
    end
    check("drain", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  vec_t             vecs[6];
  int               c0, at;
  bit               ok;
  logic [NREQ-1:0]  rv;
  int               exp_ord[5];
  int               skip_ord[3];

  initial begin
    vecs[0] = '{1, 32'h3F80_0000, 32'h4000_0000, 2'd0, 2'd0, 32'h4040_0000, 1'b0, 1'b0};
    vecs[1] = '{0, 32'h4000_0000, 32'h3F80_0000, 2'd1, 2'd1, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[2] = '{2, 32'h3FC0_0000, 32'h4020_0000, 2'd0, 2'd2, 32'h4080_0000, 1'b0, 1'b0};
    vecs[3] = '{3, 32'h1234_5678, 32'h0000_0000, 2'd2, 2'd3, 32'h7F80_0000, 1'b0, 1'b1};
    vecs[4] = '{1, 32'h0000_0000, 32'h0000_0000, 2'd3, 2'd0, 32'h7FC0_0000, 1'b1, 1'b0};
    vecs[5] = '{3, 32'h40A0_0000, 32'hC040_0000, 2'd0, 2'd0, 32'h4000_0000, 1'b0, 1'b0};
    exp_ord  = '{0, 1, 2, 3, 0};
    skip_ord = '{2, 0, 2};

    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h0, 32'h0, 2'd0, 2'd0);

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_start", bus.fpu_start, 0);
    check("rst_fpu_A", bus.fpu_A, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_Y", bus.rsp_Y, 0);
`ifdef FPU_ARB_STATS_EN
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single operations.
    for (int v = 0; v < 6; v++) begin
      single_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sel, vecs[v].rnd, c0);
      wait_rsp(20, ok, at, rv);
      check("vec_rsp_seen", ok, 1);
      check("vec_rsp_valid", rv, 1 << vecs[v].idx);
      check("vec_latency", at - c0, LAT + 2);
      check("vec_rsp_Y", bus.rsp_Y, vecs[v].y);
      check("vec_rsp_Error", bus.rsp_Error, vecs[v].e);
      check("vec_rsp_Overflow", bus.rsp_Overflow, vecs[v].o);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("hold_rsp_valid", bus.rsp_valid, 0);
    check("hold_rsp_Y", bus.rsp_Y, 32'h4000_0000);
`ifdef FPU_ARB_STATS_EN
    check("table_ovf_cnt", ovf_cnt, 1);
    check("table_err_cnt", err_cnt, 1);
`endif
    @(posedge clk); #1;

    // Contention: all four requesters valid straight out of reset.
    rst = 1'b1;
    sb_q.delete();
    grant_q.delete();
    grant_cyc_q.delete();
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 2'd0, 2'd0);
    set_req(1, 32'h4000_0000, 32'h3F80_0000, 2'd0, 2'd1);
    set_req(2, 32'h4040_0000, 32'h3F80_0000, 2'd0, 2'd2);
    set_req(3, 32'h4080_0000, 32'h3F80_0000, 2'd0, 2'd3);
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 60 && grant_q.size() < 5; k++) @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("cont_grant_count", grant_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < grant_q.size()) check("cont_order", grant_q[i], exp_ord[i]);
    for (int i = 1; i < 5; i++)
      if (i < grant_cyc_q.size()) check("cont_spacing", grant_cyc_q[i] - grant_cyc_q[i-1], LAT + 3);
    wait_idle(30);
`ifdef FPU_ARB_STATS_EN
    check("cont_err_cnt_cleared", err_cnt, 0);
`endif

    // Round-robin skip: 0 and 2 valid, last grant was 0.
    grant_q.delete();
    set_req(0, 32'h4000_0000, 32'h4000_0000, 2'd0, 2'd1);
    set_req(2, 32'h3F80_0000, 32'h3F80_0000, 2'd1, 2'd2);
    bus.req_valid = 4'b0101;
    for (int k = 0; k < 40 && grant_q.size() < 3; k++) @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("skip_grant_count", grant_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < grant_q.size()) check("skip_order", grant_q[i], skip_ord[i]);
    wait_idle(30);

    // Overflow flags, twice in a row.
    for (int n = 1; n <= 2; n++) begin
      single_op(2, 32'h7F00_0000, 32'h7F00_0000, 2'd2, 2'd0, c0);
      wait_rsp(20, ok, at, rv);
      check("ovf_rsp_seen", ok, 1);
      check("ovf_rsp_Overflow", bus.rsp_Overflow, 1);
      check("ovf_rsp_Y", bus.rsp_Y, 32'h7F80_0000);
      @(negedge clk);
`ifdef FPU_ARB_STATS_EN
      check("ovf_cnt", ovf_cnt, n);
      check("ovf_err_cnt", err_cnt, 0);
`endif
      @(posedge clk); #1;
    end

    // Reset during WAIT with the counter at 2.
    single_op(0, 32'h4000_0000, 32'h4000_0000, 2'd0, 2'd0, c0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    sb_q.delete();
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 2'd0, 2'd0);
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_start", bus.fpu_start, 0);
    check("mid_fpu_A", bus.fpu_A, 0);
    check("mid_fpu_B", bus.fpu_B, 0);
    check("mid_rsp_valid", bus.rsp_valid, 0);
    check("mid_rsp_Y", bus.rsp_Y, 0);
    check("mid_rsp_Overflow", bus.rsp_Overflow, 0);
    check("mid_ready", bus.req_ready, 0);
`ifdef FPU_ARB_STATS_EN
    check("mid_ovf_cnt", ovf_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_ready_after", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle(30);

    // Back-pressure: requester 3 raises valid while requester 1 is being served.
    single_op(1, 32'h3F80_0000, 32'h3F80_0000, 2'd1, 2'd3, c0);
    set_req(3, 32'h4000_0000, 32'h3F80_0000, 2'd0, 2'd1);
    bus.req_valid[3] = 1'b1;
    wait_ready(3, 20, ok, at);
    check("bp_ready_seen", ok, 1);
    check("bp_grant_delay", at - c0, LAT + 3);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one FPU (operands A/B, op select Sel, rounding mode round, start pulse; outputs Y/Error/Overflow) between NREQ requesters.
- Uses round-robin grant with one operation in flight at a time.
- The FPU has no done signal, so result timing comes from a fixed-latency counter.
- Sits between the client blocks and the FPU core. The FPU pattern harness can drive any single requester port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 4, cycles from the FPU start cycle to the cycle in which Y/Error/Overflow are valid (>=1).

Ports:
- Clock  input  1  single clock, rising edge
- Reset  input  1  synchronous, active-high reset
- req_valid  input  NREQ  request pending, per requester
- req_ready  output  NREQ  request accepted this cycle (one-hot or zero)
- req_A  input  32*NREQ  operand A, slice i = requester i
- req_B  input  32*NREQ  operand B
- req_Sel  input  2*NREQ  op select
- req_round  input  2*NREQ  rounding mode
- fpu_A  output  32  to FPU A
- fpu_B  output  32  to FPU B
- fpu_Sel  output  2  to FPU Sel
- fpu_round  output  2  to FPU round
- fpu_start  output  1  one-cycle start pulse to FPU
- fpu_Y  input  32  FPU result
- fpu_Error  input  1  FPU error flag
- fpu_Overflow  input  1  FPU overflow flag
- rsp_valid  output  NREQ  one-cycle result strobe, one-hot
- rsp_Y  output  32  captured result, shared by all requesters
- rsp_Error  output  1  captured error flag
- rsp_Overflow  output  1  captured overflow flag
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state = IDLE, counter = 0, last-grant pointer = NREQ-1 (requester 0 wins first). Reset asserted mid-operation aborts it: no rsp_valid, and the FPU result is discarded.
- State IDLE:
  - req_ready is combinational: bit g is high iff state == IDLE and g is the first requester with req_valid set, searching last+1, last+2, ... with wrap modulo NREQ.
  - When a grant occurs: latch requester g's A/B/Sel/round into the fpu_* registers, set last = g, go to ISSUE.
  - No request pending: stay in IDLE.
- State ISSUE (1 cycle):
  - fpu_start = 1. fpu_* are driven from the registers. Counter loads 1. Go to WAIT.
  - fpu_A/B/Sel/round hold stable from ISSUE until the cycle after the result is captured.
- State WAIT:
  - fpu_start = 0. Counter increments each cycle.
  - When counter == LATENCY: sample fpu_Y/fpu_Error/fpu_Overflow into the rsp_* registers and go to RESP.
- State RESP (1 cycle):
  - rsp_valid[g] = 1. Next state IDLE.
  - rsp_Y/Error/Overflow hold their value until the next capture; they are not cleared.
- Timing:
  - Acceptance cycle c0 -> start at c1 -> result sampled at end of c1+LATENCY -> rsp_valid at c2+LATENCY.
  - Earliest next acceptance is c3+LATENCY, giving a throughput of 1 op per LATENCY+3 cycles.
- Simultaneous requests: exactly one is granted, and the pointer rotates. A requester that holds req_valid continuously is served at least once every NREQ grants.
- A requester dropping req_valid before it sees ready: legal, nothing is latched for it.
- req_valid asserted during ISSUE/WAIT/RESP: req_ready stays 0, and the request is held by the requester.
- Counter width: $clog2(LATENCY+1); it must never wrap.

Optional Feature:
- FPU_ARB_STATS_EN defined:
  - Adds outputs err_cnt (16) and ovf_cnt (16).
  - Each increments by 1 on a RESP cycle whose captured Error/Overflow is 1, and saturates at 16'hFFFF.
  - Both clear on Reset.
- Not defined: the ports and counters are absent, and the block is otherwise identical.

Test Plan:
- Single op: bench uses a behavioral FPU model with LATENCY=4. Requester 1 sends A=3F800000, B=40000000, Sel=0, round=0, accepted at cycle c0 -> fpu_start high only at c1 with fpu_A=3F800000, fpu_B=40000000; rsp_valid=4'b0010 at c6 with rsp_Y=40400000, Error=0, Overflow=0.
- Contention: all four req_valid held high from reset -> grant order 0,1,2,3,0; successive req_ready pulses are 7 cycles apart; each rsp_valid goes to the matching requester.
- Round-robin skip: requesters 0 and 2 hold valid, last grant = 0 -> next grant is 2, then 0, then 2; requesters 1 and 3 never see ready.
- Flags: model returns Y=7F800000, Overflow=1 for Sel=2 -> rsp_Overflow=1 on the RESP cycle. With FPU_ARB_STATS_EN defined, ovf_cnt goes 0 -> 1; a second overflow gives 2.
- Reset mid-op: assert Reset during WAIT, counter=2 -> next cycle all outputs 0, busy=0, no rsp_valid ever; the next request from 0 gets ready immediately after Reset deasserts.
- Back-pressure hold: requester 3 raises valid while busy with an op for requester 1 -> req_ready[3]=0 throughout; granted in the first IDLE cycle after RESP.
